dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port data memory (asynchronous read, synchronous write, word-addressed by addr[15:2]). Port 0 is the CPU data port and port 1 is the debug/DMA loader port. Each port uses a valid/ready request handshake and gets a one-cycle response pulse. The arbiter grants round-robin, holds the memory for a fixed, configurable access latency, then returns read data or a write acknowledge.

Parameters:
LATENCY, 2, memory access cycles per request (legal range 1..15); the ACCESS state lasts this many cycles.
CNT_W, 4, width of the latency down-counter; must satisfy 2^CNT_W > LATENCY.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
req0_valid  input  1  port 0 request pending
req0_write  input  1  1 = write, 0 = read
req0_addr  input  32  byte address
req0_wdata  input  32  write data
req0_ready  output  1  port 0 request accepted this cycle
resp0_valid  output  1  one-cycle completion pulse for port 0
resp0_rdata  output  32  read data; 0 for writes
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata: same as port 0, for port 1
mem_addr  output  32  to data memory addr
mem_din  output  32  to data memory din
mem_read  output  1  to data memory mem_read
mem_write  output  1  to data memory mem_write
mem_dout  input  32  from data memory dout
busy  output  1  high in ACCESS and RESP

Behaviour:
- Reset (synchronous):
  - state = IDLE, prio = 0, counter = 0, latched request cleared.
  - All outputs are 0.
  - An in-flight request is dropped: no mem_write and no response. The requester must re-issue it.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any reqN_valid is high, grant one port and assert its reqN_ready combinationally in this cycle (cycle T).
  - Latch the port id, write flag, addr and wdata. Load counter = LATENCY-1. Go to ACCESS.
  - At most one ready is high per cycle. ready is never high outside IDLE.
- Arbitration:
  - Only one port valid: grant it.
  - Both valid: grant the port named by prio.
  - On every grant, prio becomes the other port (not the granted one).
- ACCESS (cycles T+1 .. T+LATENCY):
  - mem_addr = latched addr and mem_din = latched wdata.
  - Reads: mem_read = 1 in every ACCESS cycle.
  - counter decrements each cycle.
  - On the cycle with counter == 0:
    - Writes: mem_write = 1 for exactly this one cycle, so the memory commits at the end of it.
    - Reads: mem_dout is captured into the rdata register.
  - Then go to RESP.
- RESP (cycle T+LATENCY+1):
  - respN_valid = 1 for the latched port only.
  - respN_rdata = captured data for reads, 0 for writes.
  - mem_* outputs are 0. Go to IDLE; a new grant is possible in the next cycle.
- Outside ACCESS: mem_addr, mem_din, mem_read and mem_write are all 0.
- Outside RESP: respN_valid = 0 and respN_rdata holds its last value.
- Throughput: one request every LATENCY+2 cycles.
- Requester rules:
  - Must hold valid and payload stable until ready.
  - Dropping valid before ready is legal; no access occurs.
- Addresses: addr[1:0] and addr[31:16] pass through unmodified; the memory ignores them, so no alignment error is raised.
- Simultaneous events: a new valid arriving during ACCESS or RESP waits and is considered only in IDLE.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2)
  - port id constants (PORT_CPU=1'b0, PORT_DBG=1'b1)
  - DATA_W=32
- One sub-module, rr_arbiter2: combinational two-input round-robin picker. Inputs are req[1:0] and prio; outputs are the one-hot grant[1:0] and the next prio.
- The FSM, counter and latches stay in dmem_arbiter.

Test Plan:
1. LATENCY=2; port 0 writes 0xDEADBEEF at 0x40 with ready at cycle T -> mem_write=1 only at T+2; resp0_valid at T+3 with rdata=0; memory word 0x10 = 0xDEADBEEF.
2. Port 0 then reads 0x40 -> mem_read=1 at T+1 and T+2; resp0_valid at T+3 with rdata=0xDEADBEEF; resp1_valid stays 0.
3. Both ports hold valid continuously after reset -> grants alternate 0,1,0,1; each ready is spaced LATENCY+2=4 cycles apart.
4. Only port 1 valid, then both valid -> port 1 granted first, then port 0 (prio=0 after port 1's grant).
5. Reset asserted during ACCESS of a write -> mem_write never pulses, no response, outputs 0 the next cycle, state IDLE, memory word unchanged.
6. LATENCY=1; port 1 reads an unwritten address 0x8004 after reset -> resp1_valid at T+2 with rdata=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker: prio names the winner on a tie, and the
// loser of any grant becomes the next priority holder.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       prio_next
);

  // Pick one requester and hand priority to the other port.
  always_comb begin
    grant     = 2'b00;
    prio_next = prio;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio == PORT_DBG) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      prio_next = PORT_DBG;
    end else if (grant[1]) begin
      prio_next = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer in front of the single-port data memory.
// One request is accepted in IDLE, the memory is held for LATENCY cycles,
// then a one-cycle response pulse is returned to the granted port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [DATA_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [DATA_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        req_gated;
  logic [1:0]        grant;
  logic              prio_next;

  // Requests are only visible to the picker in IDLE and outside reset.
  always_comb begin
    req_gated = 2'b00;
    if (!reset && state_q == S_IDLE) begin
      req_gated = {req1_valid, req0_valid};
    end
  end

  rr_arbiter2 u_rr (
    .req       (req_gated),
    .prio      (prio_q),
    .grant     (grant),
    .prio_next (prio_next)
  );

  // Next-state, latches and all combinational outputs.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    busy        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          port_d     = grant[1] ? PORT_DBG : PORT_CPU;
          write_d    = grant[1] ? req1_write : req0_write;
          addr_d     = grant[1] ? req1_addr : req0_addr;
          wdata_d    = grant[1] ? req1_wdata : req0_wdata;
          cnt_d      = CNT_W'(LATENCY - 1);
          prio_d     = prio_next;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        mem_din  = wdata_q;
        mem_read = !write_q;
        if (cnt_q == '0) begin
          // Last access cycle: writes commit at this edge, reads sample dout.
          mem_write = write_q;
          if (port_q == PORT_CPU) begin
            rdata0_d = write_q ? '0 : mem_dout;
          end else begin
            rdata1_d = write_q ? '0 : mem_dout;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        busy        = 1'b1;
        resp0_valid = (port_q == PORT_CPU);
        resp1_valid = (port_q == PORT_DBG);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A request in flight when reset arrives is dropped without side effects.
    if (reset) begin
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      resp0_valid = 1'b0;
      resp1_valid = 1'b0;
      mem_addr    = '0;
      mem_din     = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      busy        = 1'b0;
    end
  end

  assign resp0_rdata = rdata0_q;
  assign resp1_rdata = rdata1_q;

  // State, counter and request/response latches with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prio_q   <= PORT_CPU;
      cnt_q    <= '0;
      port_q   <= PORT_CPU;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int LAT_A = 2;

  logic        clk;
  logic        reset;

  // Instance A (LATENCY=2)
  logic        req0_valid, req0_write, req0_ready, resp0_valid;
  logic [31:0] req0_addr, req0_wdata, resp0_rdata;
  logic        req1_valid, req1_write, req1_ready, resp1_valid;
  logic [31:0] req1_addr, req1_wdata, resp1_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_a [0:16383];

  // Instance B (LATENCY=1), port 0 tied off
  logic        b_req0_ready, b_resp0_valid;
  logic [31:0] b_resp0_rdata;
  logic        b_req1_valid, b_req1_write, b_req1_ready, b_resp1_valid;
  logic [31:0] b_req1_addr, b_req1_wdata, b_resp1_rdata;
  logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;
  logic        b_mem_read, b_mem_write, b_busy;
  logic [31:0] mem_b [0:16383];

  int checks;
  int fails;

  dmem_arbiter #(.LATENCY(LAT_A), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
    .mem_dout(mem_dout), .busy(busy)
  );

  dmem_arbiter #(.LATENCY(1), .CNT_W(4)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(1'b0), .req0_write(1'b0), .req0_addr(32'h0),
    .req0_wdata(32'h0), .req0_ready(b_req0_ready), .resp0_valid(b_resp0_valid),
    .resp0_rdata(b_resp0_rdata),
    .req1_valid(b_req1_valid), .req1_write(b_req1_write), .req1_addr(b_req1_addr),
    .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready), .resp1_valid(b_resp1_valid),
    .resp1_rdata(b_resp1_rdata),
    .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_dout(b_mem_dout), .busy(b_busy)
  );

  // Data memories: asynchronous read, synchronous write, word index addr[15:2].
  assign mem_dout   = mem_a[mem_addr[15:2]];
  assign b_mem_dout = mem_b[b_mem_addr[15:2]];

  always @(posedge clk) begin
    if (mem_write) mem_a[mem_addr[15:2]] <= mem_din;
    if (b_mem_write) mem_b[b_mem_addr[15:2]] <= b_mem_din;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive point is just after the rising edge; sample point is the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    b_req1_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [134:0] got;
    step();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sample();
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
    step();
    sample();
    got = {req1_ready, req0_ready, resp1_valid, resp0_valid, mem_read, mem_write, busy,
           mem_addr, mem_din, resp0_rdata, resp1_rdata};
    checks++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    step();
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sample();
    got = {req1_ready, req0_ready, resp1_valid, resp0_valid, mem_read, mem_write, busy,
           mem_addr, mem_din, resp0_rdata, resp1_rdata};
    checks++;
    if (got !== '0) begin
      fails++;
      $display("FAIL post_reset_outputs: got %h want 0", got);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    // Write 0xDEADBEEF to 0x40
    step();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h40; req0_wdata = 32'hDEADBEEF;
    sample();
    checks++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL wr_ready: got %b want 1", req0_ready);
    end
    step(); req0_valid = 1'b0; sample();
    checks++;
    if ({mem_write, mem_read, busy, mem_addr} !== {1'b0, 1'b0, 1'b1, 32'h40}) begin
      fails++;
      $display("FAIL wr_t1: got w%b r%b b%b a%h want w0 r0 b1 a00000040",
               mem_write, mem_read, busy, mem_addr);
    end
    step(); sample();
    checks++;
    if ({mem_write, mem_addr, mem_din} !== {1'b1, 32'h40, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL wr_t2: got w%b a%h d%h want w1 a00000040 ddeadbeef",
               mem_write, mem_addr, mem_din);
    end
    step(); sample();
    checks++;
    if ({resp0_valid, resp1_valid, mem_write, resp0_rdata} !== {3'b100, 32'h0}) begin
      fails++;
      $display("FAIL wr_resp: got v0%b v1%b w%b rd%h want v0 1 v1 0 w0 rd0",
               resp0_valid, resp1_valid, mem_write, resp0_rdata);
    end
    checks++;
    if (mem_a[16] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL wr_mem: got %h want deadbeef", mem_a[16]);
    end
    // Read it back
    step();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h40; req0_wdata = 32'h0;
    sample();
    checks++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL rd_ready: got %b want 1", req0_ready);
    end
    step(); req0_valid = 1'b0; sample();
    checks++;
    if ({mem_read, mem_write, mem_addr} !== {2'b10, 32'h40}) begin
      fails++; $display("FAIL rd_t1: got r%b w%b a%h want r1 w0", mem_read, mem_write, mem_addr);
    end
    step(); sample();
    checks++;
    if ({mem_read, mem_write, resp0_valid} !== 3'b100) begin
      fails++; $display("FAIL rd_t2: got r%b w%b v%b want r1 w0 v0", mem_read, mem_write,
                        resp0_valid);
    end
    step(); sample();
    checks++;
    if ({resp0_valid, resp1_valid, mem_read, resp0_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL rd_resp: got v0%b v1%b r%b rd%h want v0 1 v1 0 r0 rd deadbeef",
               resp0_valid, resp1_valid, mem_read, resp0_rdata);
    end
    step(); sample();
    checks++;
    if ({resp0_valid, resp0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      fails++; $display("FAIL rd_hold: got v%b rd%h want v0 rd deadbeef", resp0_valid,
                        resp0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    step();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h40;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h44;
    for (int k = 0; k < 20; k++) begin
      sample();
      want = 2'b00;
      if (k % (LAT_A + 2) == 0) want = ((k / (LAT_A + 2)) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({req1_ready, req0_ready} !== want) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got ready %b want %b", k, {req1_ready, req0_ready}, want);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_port1_first();
    do_reset();
    step();
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h100;
    sample();
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      fails++; $display("FAIL p1_first: got ready %b want 10", {req1_ready, req0_ready});
    end
    step();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h104;
    for (int k = 1; k <= LAT_A + 2; k++) begin
      sample();
      checks++;
      if ({req1_ready, req0_ready} !== ((k == LAT_A + 2) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL p0_second_cycle%0d: got ready %b", k, {req1_ready, req0_ready});
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (LAT_A + 2) step();
  endtask

  task automatic test_reset_in_access();
    logic [134:0] got;
    do_reset();
    step();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h80; req0_wdata = 32'h11111111;
    step(); req0_valid = 1'b0;
    repeat (LAT_A + 1) step();
    // Second write is interrupted in its commit cycle
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h80; req0_wdata = 32'hCAFEF00D;
    sample();
    checks++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL rst_acc_ready: got %b want 1", req0_ready);
    end
    step(); req0_valid = 1'b0;
    step(); reset = 1'b1; sample();
    checks++;
    if ({mem_write, resp0_valid} !== 2'b00) begin
      fails++; $display("FAIL rst_acc_nowrite: got w%b v%b want w0 v0", mem_write, resp0_valid);
    end
    step(); reset = 1'b0; sample();
    got = {req1_ready, req0_ready, resp1_valid, resp0_valid, mem_read, mem_write, busy,
           mem_addr, mem_din, resp0_rdata, resp1_rdata};
    checks++;
    if (got !== '0) begin
      fails++; $display("FAIL rst_acc_outputs: got %h want 0", got);
    end
    checks++;
    if (mem_a[32] !== 32'h11111111) begin
      fails++; $display("FAIL rst_acc_mem: got %h want 11111111", mem_a[32]);
    end
    // Idle again: a fresh read is accepted at once and sees the old word
    step();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h80;
    sample();
    checks++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL rst_acc_idle: got ready %b want 1", req0_ready);
    end
    step(); req0_valid = 1'b0;
    repeat (LAT_A) step();
    sample();
    checks++;
    if ({resp0_valid, resp0_rdata} !== {1'b1, 32'h11111111}) begin
      fails++; $display("FAIL rst_acc_reread: got v%b rd%h want v1 rd11111111", resp0_valid,
                        resp0_rdata);
    end
    step();
  endtask

  task automatic test_latency1();
    do_reset();
    step();
    b_req1_valid = 1'b1; b_req1_write = 1'b0; b_req1_addr = 32'h8004; b_req1_wdata = 32'h0;
    sample();
    checks++;
    if ({b_req1_ready, b_req0_ready} !== 2'b10) begin
      fails++; $display("FAIL l1_ready: got %b want 10", {b_req1_ready, b_req0_ready});
    end
    step(); b_req1_valid = 1'b0; sample();
    checks++;
    if ({b_mem_read, b_mem_write, b_mem_addr, b_resp1_valid} !== {2'b10, 32'h8004, 1'b0}) begin
      fails++; $display("FAIL l1_access: got r%b w%b a%h v%b", b_mem_read, b_mem_write,
                        b_mem_addr, b_resp1_valid);
    end
    step(); sample();
    checks++;
    if ({b_resp1_valid, b_resp0_valid, b_resp1_rdata, b_busy} !== {2'b10, 32'h0, 1'b1}) begin
      fails++; $display("FAIL l1_resp: got v1%b v0%b rd%h b%b want v1 1 v0 0 rd0 b1",
                        b_resp1_valid, b_resp0_valid, b_resp1_rdata, b_busy);
    end
    step(); sample();
    checks++;
    if ({b_resp1_valid, b_busy} !== 2'b00) begin
      fails++; $display("FAIL l1_after: got v%b b%b want 00", b_resp1_valid, b_busy);
    end
  endtask

  // Randomized traffic against a transaction-level model: each accepted request
  // owns the memory for LAT_A cycles after its grant and responds one cycle later.
  task automatic test_random();
    localparam int N = 600;
    logic [31:0]  ref_mem [0:63];
    bit           pend [2];
    bit           pw [2];
    logic [31:0]  pa [2];
    logic [31:0]  pd [2];
    bit           m_busy, m_port, m_write, prio_m, g, do_commit;
    int           t_g, ph;
    logic [31:0]  m_addr, m_wdata, m_rdata;
    logic [31:0]  last_rd [2];
    logic [1:0]   e_rdy, e_rv;
    logic         e_rd, e_wr, e_busy;
    logic [31:0]  e_a, e_d;
    logic [134:0] got, exp_v;

    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem_a[i];
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pw[p] = 1'b0; pa[p] = '0; pd[p] = '0; last_rd[p] = '0;
    end
    m_busy = 1'b0; prio_m = 1'b0; m_port = 1'b0; m_write = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; t_g = 0;

    for (int c = 0; c < N + LAT_A + 4; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (c >= N) begin
          pend[p] = 1'b0;
        end else if (pend[p]) begin
          if ($urandom_range(15) == 0) pend[p] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          pend[p] = 1'b1;
          pw[p]   = 1'($urandom_range(1));
          pa[p]   = {16'($urandom()), 8'h00, 6'($urandom()), 2'($urandom())};
          pd[p]   = $urandom();
        end
      end
      req0_valid = pend[0]; req0_write = pw[0]; req0_addr = pa[0]; req0_wdata = pd[0];
      req1_valid = pend[1]; req1_write = pw[1]; req1_addr = pa[1]; req1_wdata = pd[1];
      sample();

      e_rdy = 2'b00; e_rv = 2'b00; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
      e_a = '0; e_d = '0; do_commit = 1'b0;
      if (!m_busy) begin
        if (pend[0] || pend[1]) begin
          g = (pend[0] && pend[1]) ? prio_m : pend[1];
          e_rdy[g] = 1'b1;
          m_busy = 1'b1; t_g = c; m_port = g;
          m_write = pw[g]; m_addr = pa[g]; m_wdata = pd[g];
          prio_m = !g;
          pend[g] = 1'b0;
        end
      end else begin
        ph = c - t_g;
        e_busy = 1'b1;
        if (ph <= LAT_A) begin
          e_a = m_addr; e_d = m_wdata; e_rd = !m_write;
          e_wr = m_write && (ph == LAT_A);
          if (ph == LAT_A) begin
            if (m_write) do_commit = 1'b1;
            else m_rdata = ref_mem[m_addr[7:2]];
          end
        end else begin
          e_rv[m_port] = 1'b1;
          last_rd[m_port] = m_write ? 32'h0 : m_rdata;
          m_busy = 1'b0;
        end
      end

      got = {req1_ready, req0_ready, resp1_valid, resp0_valid, mem_read, mem_write, busy,
             mem_addr, mem_din, resp0_rdata, resp1_rdata};
      exp_v = {e_rdy, e_rv, e_rd, e_wr, e_busy, e_a, e_d, last_rd[0], last_rd[1]};
      checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL rand_cycle%0d: got %h want %h", c, got, exp_v);
      end
      if (do_commit) ref_mem[m_addr[7:2]] = m_wdata;
    end

    step();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem_a[i] !== ref_mem[i]) begin
        fails++;
        $display("FAIL rand_mem[%0d]: got %h want %h", i, mem_a[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    b_req1_valid = 1'b0; b_req1_write = 1'b0; b_req1_addr = '0; b_req1_wdata = '0;
    for (int i = 0; i < 16384; i++) begin
      mem_a[i] <= '0;
      mem_b[i] <= '0;
    end

    test_reset();
    test_write_read();
    test_back_to_back();
    test_port1_first();
    test_reset_in_access();
    test_latency1();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
